// File: rtl/uart_fifo_buffer_if.sv
// ---------------------------------------------------------------------------
// uart_fifo_buffer_if
//   Serial line bundle for the UART store-and-forward buffer.
//
//   Signals:
//     rx  - UART serial data into the buffer (idle high)
//     tx  - UART serial data out of the buffer, carrying queued bytes (idle high)
//     tx2 - auxiliary serial output (echo of the synchronized rx line when enabled)
//
//   Modports:
//     master - the host/line side: drives rx, observes tx and tx2
//     slave  - the buffer itself: observes rx, drives tx and tx2
// ---------------------------------------------------------------------------
interface uart_fifo_buffer_if;
  logic rx;
  logic tx;
  logic tx2;

  modport master (output rx, input tx, input tx2);
  modport slave  (input rx, output tx, output tx2);
endinterface

// File: rtl/uart_fifo_buffer.sv
// ---------------------------------------------------------------------------
// uart_fifo_buffer
//   UART store-and-forward buffer. 8N1 bytes received on bus.rx are queued in
//   a DEPTH-entry FIFO and re-sent in arrival order on bus.tx once the line
//   has been quiet for IDLE_CLKS clocks with data queued, or as soon as the
//   FIFO fills. Reception continues while a drain is in progress.
//
//   Ports:
//     clock - system clock, rising edge
//     reset - asynchronous, active-low reset
//     bus   - serial lines (slave modport): rx in, tx out, tx2 out
//
//   Parameters:
//     CLKS_PER_BIT - system clocks per UART bit
//     DEPTH        - FIFO entries (power of two)
//     ADDR_W       - log2(DEPTH)
//     IDLE_CLKS    - quiet-line clocks that start a drain when data is queued
//
//   Build option:
//     TX2_ECHO_EN - when defined, bus.tx2 echoes the synchronized rx line one
//                   register stage later; otherwise bus.tx2 is tied high.
// ---------------------------------------------------------------------------
module uart_fifo_buffer #(
  parameter int CLKS_PER_BIT = 1250,
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 4,
  parameter int IDLE_CLKS    = 120000
) (
  input  logic              clock,
  input  logic              reset,
  uart_fifo_buffer_if.slave bus
);

  localparam int CNT_W  = $clog2(CLKS_PER_BIT + 1);
  localparam int IDLE_W = $clog2(IDLE_CLKS + 1);

  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(IDLE_CLKS);
  localparam logic [ADDR_W:0]   FULL      = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_state_e;

  // ---------------------------------------------------------------- state
  logic              rx_meta_q, rx_meta_d;
  logic              rx_sync_q, rx_sync_d;
  logic              rx_prev_q, rx_prev_d;

  uart_state_e       rx_state_q, rx_state_d;
  logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
  logic [2:0]        rx_bit_q, rx_bit_d;
  logic [7:0]        rx_shift_q, rx_shift_d;
  logic              rx_push;

  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic              drain_q, drain_d;

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [7:0]        fifo_mem [DEPTH];
  logic              fifo_full, fifo_empty, push_ok;

  uart_state_e       tx_state_q, tx_state_d;
  logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
  logic [2:0]        tx_bit_q, tx_bit_d;
  logic [7:0]        tx_shift_q, tx_shift_d;
  logic              tx_q, tx_d;
  logic              tx_pop;

  assign fifo_full  = (count_q == FULL);
  assign fifo_empty = (count_q == '0);

  // ------------------------------------------------ rx synchronizer chain
  // rx_prev_q is one stage behind rx_sync_q and only serves edge detection.
  always_comb begin
    rx_meta_d = bus.rx;
    rx_sync_d = rx_meta_q;
    rx_prev_d = rx_sync_q;
  end

  // ------------------------------------------------------------ receiver
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_push    = 1'b0;
    case (rx_state_q)
      ST_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = ST_START;
          rx_cnt_d   = '0;
        end
      end
      ST_START: begin
        // Half a bit in: a line that is high again was only a glitch.
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? ST_IDLE : ST_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) begin
            rx_state_d = ST_STOP;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      ST_STOP: begin
        // A low stop bit is a framing error: the byte is silently dropped.
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_push    = rx_sync_q;
          rx_state_d = ST_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      default: rx_state_d = ST_IDLE;
    endcase
  end

  // ------------------------------------------- quiet-line timer and drain
  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (!rx_sync_q || (rx_state_q != ST_IDLE)) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q != IDLE_MAX) begin
      idle_cnt_d = idle_cnt_q + IDLE_W'(1);
    end

    drain_d = drain_q;
    if (((idle_cnt_q == IDLE_MAX) && !fifo_empty) || fifo_full) begin
      drain_d = 1'b1;
    end else if (fifo_empty && (tx_state_q == ST_IDLE)) begin
      drain_d = 1'b0;
    end
  end

  // --------------------------------------------------------- transmitter
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      ST_IDLE: begin
        if (drain_q && !fifo_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = fifo_mem[rd_ptr_q];
          tx_cnt_d   = '0;
          tx_state_d = ST_START;
        end
      end
      ST_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = ST_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          tx_bit_d = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = ST_STOP;
          end else begin
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = ST_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      default: tx_state_d = ST_IDLE;
    endcase

    // Line level is registered from the next state so tx is glitch-free.
    case (tx_state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = tx_shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------- FIFO
  // When full, a push only lands if a pop frees the slot in the same cycle.
  assign push_ok = rx_push && (!fifo_full || tx_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end
    if (tx_pop) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end
    case ({push_ok, tx_pop})
      2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
      2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage carries no reset; a reset only clears the pointers and count.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_q] <= rx_shift_q;
    end
  end

  // ------------------------------------------------------------ registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= ST_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      idle_cnt_q <= '0;
      drain_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tx_state_q <= ST_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
    end else begin
      rx_meta_q  <= rx_meta_d;
      rx_sync_q  <= rx_sync_d;
      rx_prev_q  <= rx_prev_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      idle_cnt_q <= idle_cnt_d;
      drain_q    <= drain_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
    end
  end

  assign bus.tx = tx_q;

  // --------------------------------------------------------- tx2 output
`ifdef TX2_ECHO_EN
  logic echo_q, echo_d;

  assign echo_d = rx_sync_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      echo_q <= 1'b1;
    end else begin
      echo_q <= echo_d;
    end
  end

  assign bus.tx2 = echo_q;
`else
  assign bus.tx2 = 1'b1;
`endif

endmodule

// File: tb/tb_uart_fifo_buffer.sv
// ---------------------------------------------------------------------------
// tb_uart_fifo_buffer
//   Self-checking bench for uart_fifo_buffer with shortened bit and quiet
//   times. A line monitor decodes every tx frame into a queue; expected byte
//   streams come from a simple ordered-queue model of the buffer.
// ---------------------------------------------------------------------------
module tb_uart_fifo_buffer;

  localparam int CPB    = 16;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int IDLE   = 400;
  localparam int FRAME  = 10 * CPB + 1;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  uart_fifo_buffer_if tb_if ();

  uart_fifo_buffer #(
    .CLKS_PER_BIT(CPB),
    .DEPTH       (DEPTH),
    .ADDR_W      (ADDR_W),
    .IDLE_CLKS   (IDLE)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (tb_if)
  );

  int         n_total = 0;
  int         n_bad   = 0;
  logic [7:0] got_q[$];
  int         n_starts = 0;
  int         last_start_len = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Drive one 8N1 frame; stop_ok = 0 forces a framing error.
  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    logic [9:0] fr;
    fr = {stop_ok, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      tb_if.rx = fr[i];
      repeat (CPB) @(negedge clock);
    end
    tb_if.rx = 1'b1;
  endtask

  task automatic wait_frames(input int n, input int budget, input string name);
    int k;
    k = 0;
    while ((got_q.size() < n) && (k < budget)) begin
      @(negedge clock);
      k++;
    end
    check(name, got_q.size(), n);
  endtask

  // Line monitor: decodes tx frames by sampling at bit centres.
  initial begin : monitor
    logic       prev;
    logic [7:0] d;
    logic       smp_start, smp_stop;
    bit         ab, rose;
    int         slen;
    prev = 1'b1;
    forever begin
      @(negedge clock);
      if (reset && prev && !tb_if.tx) begin
        n_starts++;
        ab = 1'b0; rose = 1'b0; slen = 1; d = '0;
        smp_start = 1'b1; smp_stop = 1'b0;
        for (int t = 1; t <= 9 * CPB + CPB / 2; t++) begin
          @(negedge clock);
          if (!reset) ab = 1'b1;
          if (!rose) begin
            if (tb_if.tx) rose = 1'b1;
            else slen++;
          end
          if (t == CPB / 2) smp_start = tb_if.tx;
          if ((t > CPB) && (t < 9 * CPB) && ((t % CPB) == CPB / 2))
            d[t / CPB - 1] = tb_if.tx;
          if (t == 9 * CPB + CPB / 2) smp_stop = tb_if.tx;
        end
        if (!ab) begin
          check("mon_start_bit", int'(smp_start), 0);
          check("mon_stop_bit", int'(smp_stop), 1);
          got_q.push_back(d);
          last_start_len = slen;
        end
      end
      prev = tb_if.tx;
    end
  end

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    int         exp_frames;
    logic [7:0] exp_data;
    bit         chk_len;
  } vec_t;

  vec_t       vecs[8];
  logic [7:0] exp_q[$];

  initial begin : main
    int s0, k, n, gap;
    logic [7:0] b;
    bit ok;
    logic [2:0] hist;
    logic v;

    vecs[0] = '{8'h01, 1'b1, 1, 8'h01, 1'b1};
    vecs[1] = '{8'h55, 1'b0, 0, 8'h00, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 1, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 1'b1, 1, 8'h00, 1'b0};
    vecs[4] = '{8'hA5, 1'b1, 1, 8'hA5, 1'b1};
    vecs[5] = '{8'h80, 1'b1, 1, 8'h80, 1'b0};
    vecs[6] = '{8'h55, 1'b1, 1, 8'h55, 1'b1};
    vecs[7] = '{8'hC3, 1'b0, 0, 8'h00, 1'b0};

    // ---- reset and idle line
    tb_if.rx = 1'b1;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_tx", int'(tb_if.tx), 1);
    check("rst_tx2", int'(tb_if.tx2), 1);
    reset = 1'b1;
    @(negedge clock);
    check("post_rst_tx", int'(tb_if.tx), 1);
    check("post_rst_tx2", int'(tb_if.tx2), 1);
    repeat (2 * IDLE) @(negedge clock);
    check("idle_no_frames", n_starts, 0);

    // ---- single-byte vectors
    for (int i = 0; i < 8; i++) begin
      got_q.delete();
      s0 = n_starts;
      send_byte(vecs[i].data, vecs[i].stop_ok);
      repeat (IDLE / 2) @(negedge clock);
      check($sformatf("vec%0d_no_early_tx", i), n_starts - s0, 0);
      repeat (IDLE / 2 + 2 * FRAME + 50) @(negedge clock);
      check($sformatf("vec%0d_frames", i), got_q.size(), vecs[i].exp_frames);
      if (got_q.size() > 0)
        check($sformatf("vec%0d_data", i), int'(got_q[0]), int'(vecs[i].exp_data));
      if (vecs[i].chk_len)
        check($sformatf("vec%0d_start_len", i), last_start_len, CPB);
    end

    // ---- bytes 1..9, gaps shorter than the quiet time
    got_q.delete();
    exp_q.delete();
    s0 = n_starts;
    for (int i = 1; i <= 9; i++) begin
      send_byte(8'(i), 1'b1);
      exp_q.push_back(8'(i));
      repeat (40) @(negedge clock);
    end
    check("burst9_no_early_tx", n_starts - s0, 0);
    wait_frames(9, IDLE + 9 * FRAME + 200, "burst9_frames");
    for (int i = 0; i < 9 && i < got_q.size(); i++)
      check($sformatf("burst9_byte%0d", i), int'(got_q[i]), int'(exp_q[i]));
    repeat (IDLE + FRAME) @(negedge clock);
    check("burst9_empty_after", n_starts - s0, 9);

    // ---- bytes 10..25 fill the FIFO: drain must start on the 16th push
    got_q.delete();
    exp_q.delete();
    s0 = n_starts;
    for (int i = 10; i <= 25; i++) begin
      if (i == 25) check("full_no_early_tx", n_starts - s0, 0);
      send_byte(8'(i), 1'b1);
      exp_q.push_back(8'(i));
      if (i != 25) repeat (40) @(negedge clock);
    end
    k = 0;
    while ((n_starts == s0) && (k < CPB)) begin
      @(negedge clock);
      k++;
    end
    check("full_drain_started", n_starts - s0, 1);
    wait_frames(16, 16 * FRAME + 200, "full_frames");
    for (int i = 0; i < 16 && i < got_q.size(); i++)
      check($sformatf("full_byte%0d", i), int'(got_q[i]), int'(exp_q[i]));
    repeat (IDLE + FRAME) @(negedge clock);
    check("full_total_frames", n_starts - s0, 16);

    // ---- randomized bursts against an ordered-queue model
    for (int r = 0; r < 5; r++) begin
      got_q.delete();
      exp_q.delete();
      n = $urandom_range(1, DEPTH);
      for (int j = 0; j < n; j++) begin
        b = 8'($urandom_range(0, 255));
        ok = ($urandom_range(0, 9) != 0);
        send_byte(b, ok);
        if (ok) exp_q.push_back(b);
        gap = $urandom_range(0, 450);
        if (!ok && gap < CPB) gap = CPB;   // line must rise before next start
        repeat (gap) @(negedge clock);
      end
      wait_frames(exp_q.size(), IDLE + DEPTH * FRAME + 500,
                  $sformatf("rand%0d_frames", r));
      repeat (FRAME + 50) @(negedge clock);
      check($sformatf("rand%0d_no_extra", r), got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
        check($sformatf("rand%0d_byte%0d", r, i), int'(got_q[i]), int'(exp_q[i]));
    end

    // ---- reset in the middle of a tx frame of 0x20
    got_q.delete();
    s0 = n_starts;
    send_byte(8'h20, 1'b1);
    k = 0;
    while ((n_starts == s0) && (k < IDLE + FRAME + 100)) begin
      @(negedge clock);
      k++;
    end
    check("rstmid_frame_started", n_starts - s0, 1);
    repeat (3 * CPB + CPB / 2) @(negedge clock);
    check("rstmid_tx_low_before", int'(tb_if.tx), 0);
    #2 reset = 1'b0;
    #1 check("rstmid_tx_high", int'(tb_if.tx), 1);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    s0 = n_starts;
    repeat (2 * IDLE + FRAME) @(negedge clock);
    check("rstmid_no_frame", n_starts - s0, 0);
    check("rstmid_no_bytes", got_q.size(), 0);

    // ---- tx2: echo of rx three clocks later, or tied high
    hist = 3'b111;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
`ifdef TX2_ECHO_EN
      check($sformatf("tx2_echo%0d", i), int'(tb_if.tx2), int'(hist[2]));
`else
      check($sformatf("tx2_tied%0d", i), int'(tb_if.tx2), 1);
`endif
      v = 1'($urandom_range(0, 1));
      tb_if.rx = v;
      hist = {hist[1:0], v};
    end
    tb_if.rx = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
